complement_serial: RTL and testbench

COMPLEMENT_SERIAL -- requirements
Module: complement_serial

---
 rtl/complement_serial.sv | 107 ++++++++++
 tb/tb_complement_serial.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/complement_serial.sv
// Serial complement unit: converts a W-bit operand CHUNK bits per cycle (pass,
// ones' complement, two's negate, sign-magnitude to two's complement).
module complement_serial #(
  parameter int unsigned W     = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] a,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned N  = W / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q;
  logic [1:0]     mode_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   op_word;
  logic [CHUNK-1:0] op_slice;
  logic [CHUNK:0] sum;
  logic           neg_sm, invert, add, cin, last;

  // Negative sign-magnitude operands become a negate of the magnitude, so every
  // mode reduces to optional invert plus optional +1 injected at the LSB slice.
  always_comb begin
    neg_sm   = (mode_q == 2'b11) && a_q[W-1];
    op_word  = neg_sm ? {1'b0, a_q[W-2:0]} : a_q;
    invert   = (mode_q == 2'b01) || (mode_q == 2'b10) || neg_sm;
    add      = (mode_q == 2'b10) || neg_sm;
    cin      = (cnt_q == '0) ? 1'b1 : carry_q;
    op_slice = op_word[cnt_q*CHUNK +: CHUNK];
    sum      = {1'b0, (invert ? ~op_slice : op_slice)} + {{CHUNK{1'b0}}, (add & cin)};
    acc_d    = acc_q;
    acc_d[cnt_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    last     = (cnt_q == CW'(N-1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            mode_q  <= mode;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          carry_q <= sum[CHUNK];
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            cnt_q  <= '0;
            result <= acc_d;
            ovf    <= (mode_q == 2'b10) && (a_q == MIN_NEG);
            zero   <= (acc_d == '0);
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_q == IDLE);

endmodule

// File: tb/tb_complement_serial.sv
// Directed plus randomized bench for complement_serial (W=16, CHUNK=4) with an
// arithmetic reference model.
module tb_complement_serial;

  localparam int unsigned W     = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned N     = W / CHUNK;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic         ready, done, ovf, zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  complement_serial #(.W(W), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a),
    .ready(ready), .done(done), .result(result), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] x, input logic [1:0] m,
                                output logic [15:0] r, output logic o);
    o = 1'b0;
    case (m)
      2'b00: r = x;
      2'b01: r = ~x;
      2'b10: begin r = 16'(17'h10000 - x); o = (x == 16'h8000); end
      default: r = x[15] ? 16'(17'h10000 - {1'b0, x[14:0]}) : x;
    endcase
  endfunction

  // Called in a cycle where the DUT is idle; returns in the done cycle.
  task automatic run(input logic [15:0] x, input logic [1:0] m, input bit disturb);
    logic [15:0] er;
    logic        eo;
    model(x, m, er, eo);
    check("ready_pre", ready, 1);
    start = 1'b1; a = x; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= N; i++) begin
      check("ready_run", ready, 0);
      check("done_early", done, 0);
      if (disturb) begin start = 1'b1; a = ~x; mode = ~m; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done", done, 1);
    check("result", result, er);
    check("ovf", ovf, eo);
    check("zero", zero, (er == 16'h0));
    check("ready_done", ready, 1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
    check("result_hold_zero", zero, (result == '0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; a = '0;
    #3;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(16'h0005, 2'b10, 1'b0);
    idle_cycle();
    run(16'h8000, 2'b10, 1'b0);
    run(16'h0000, 2'b10, 1'b0);
    run(16'h8005, 2'b11, 1'b0);
    run(16'h0005, 2'b11, 1'b0);
    run(16'h8000, 2'b11, 1'b0);
    run(16'h00F0, 2'b01, 1'b0);
    run(16'h1234, 2'b00, 1'b0);
    idle_cycle();
    run(16'h0F01, 2'b10, 1'b1);
    run(16'hFFFF, 2'b11, 1'b1);
    idle_cycle();

    // Abort a conversion after two RUN cycles.
    start = 1'b1; a = 16'h0777; mode = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    check("abort_ovf", ovf, 0);
    check("abort_zero", zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
      check("abort_result_hold", result, 0);
    end
    run(16'h0777, 2'b10, 1'b0);
    idle_cycle();

    for (int t = 0; t < 60; t++) begin
      logic [15:0] x;
      logic [1:0]  m;
      int unsigned sel;
      m   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      case (sel)
        0: x = 16'h8000;
        1: x = 16'h0000;
        2: x = 16'hFFFF;
        default: x = 16'($urandom);
      endcase
      run(x, m, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
